// File: rtl/chirp_cfg_tx.sv
// clk_48-side initiator of the 4-phase REQ/ACK transfer of chirp parameters to the clk_96 DDS.
// Optional handshake timeout is enabled by defining CHIRP_TX_TIMEOUT_EN.
module chirp_cfg_tx #(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic        clk_48,
  input  logic        rst,
  input  logic        cfg_wr,
  input  logic [47:0] cfg_freq,
  input  logic [47:0] cfg_delta_freq,
  input  logic [31:0] cfg_delta_rate,
  output logic        REQ,
  input  logic        ACK,
  output logic [47:0] DDS_freq,
  output logic [47:0] DDS_delta_freq,
  output logic [31:0] DDS_delta_rate,
  output logic        busy,
  output logic        done,
  output logic        overrun,
  output logic        timeout_err
);

  typedef enum logic [1:0] {IDLE, REQ_HI, REQ_LO} state_t;

  state_t      state, state_nxt;
  logic        ack_m, ack_s;
  logic [1:0]  arm_p;
  logic        launch, launch_cfg, done_nxt, pend_wr, hs_abort;
  logic        pend_vld;
  logic [47:0] pend_freq, pend_delta_freq;
  logic [31:0] pend_delta_rate;

  if (TIMEOUT_CYC < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 2");
  end

  // ACK synchronizer; arm_p marks when ack_s reflects real samples again after reset
  always_ff @(posedge clk_48) begin
    if (rst) begin
      ack_m <= 1'b0;
      ack_s <= 1'b0;
      arm_p <= 2'b00;
    end else begin
      ack_m <= ACK;
      ack_s <= ack_m;
      arm_p <= {arm_p[0], 1'b1};
    end
  end

`ifdef CHIRP_TX_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] to_cnt;
  logic             to_err;

  always_ff @(posedge clk_48) begin
    if (rst || launch)
      to_cnt <= '0;
    else if (state != IDLE)
      to_cnt <= to_cnt + 1'b1;
  end

  assign hs_abort = (state != IDLE) && (to_cnt == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk_48) begin
    if (rst || launch)
      to_err <= 1'b0;
    else if (hs_abort)
      to_err <= 1'b1;
  end

  assign timeout_err = to_err;
`else
  assign hs_abort    = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    state_nxt  = state;
    launch     = 1'b0;
    launch_cfg = 1'b0;
    done_nxt   = 1'b0;
    case (state)
      IDLE: begin
        // never raise REQ while the far side still shows a stale ACK
        if (arm_p[1] && !ack_s && (cfg_wr || pend_vld)) begin
          launch     = 1'b1;
          launch_cfg = cfg_wr;
          state_nxt  = REQ_HI;
        end
      end
      REQ_HI: begin
        if (hs_abort)
          state_nxt = IDLE;
        else if (ack_s)
          state_nxt = REQ_LO;
      end
      REQ_LO: begin
        if (hs_abort) begin
          state_nxt = IDLE;
        end else if (!ack_s) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign pend_wr = cfg_wr && !launch_cfg;
  assign busy    = (state != IDLE);

  always_ff @(posedge clk_48) begin
    if (rst) begin
      state    <= IDLE;
      REQ      <= 1'b0;
      done     <= 1'b0;
      overrun  <= 1'b0;
      pend_vld <= 1'b0;
    end else begin
      state <= state_nxt;
      REQ   <= (state_nxt == REQ_HI);
      done  <= done_nxt;
      if (cfg_wr && pend_vld)
        overrun <= 1'b1;
      if (pend_wr)
        pend_vld <= 1'b1;
      else if (launch)
        pend_vld <= 1'b0;
    end
  end

  always_ff @(posedge clk_48) begin
    if (pend_wr) begin
      pend_freq       <= cfg_freq;
      pend_delta_freq <= cfg_delta_freq;
      pend_delta_rate <= cfg_delta_rate;
    end
  end

  always_ff @(posedge clk_48) begin
    if (rst) begin
      DDS_freq       <= '0;
      DDS_delta_freq <= '0;
      DDS_delta_rate <= '0;
    end else if (launch) begin
      DDS_freq       <= launch_cfg ? cfg_freq       : pend_freq;
      DDS_delta_freq <= launch_cfg ? cfg_delta_freq : pend_delta_freq;
      DDS_delta_rate <= launch_cfg ? cfg_delta_rate : pend_delta_rate;
    end
  end

endmodule

// File: tb/tb_chirp_cfg_tx.sv
// Self-checking bench for chirp_cfg_tx: table/random transfer cases against a
// latest-wins queue model, plus hand-timed handshake, reset and timeout sequences.
module tb_chirp_cfg_tx;

  logic        clk_48 = 1'b0;
  logic        rst, cfg_wr;
  logic [47:0] cfg_freq, cfg_delta_freq;
  logic [31:0] cfg_delta_rate;
  logic        REQ, ACK;
  logic [47:0] DDS_freq, DDS_delta_freq;
  logic [31:0] DDS_delta_rate;
  logic        busy, done, overrun, timeout_err;

  bit          resp_en;
  logic        ack_rsp, ack_man;
  int          resp_rise, resp_fall;

  int          n_chk = 0, n_fail = 0;
  int          cyc = 0, done_cnt = 0, stable_err = 0;
  logic        prev_req = 1'b0;
  logic [127:0] cur_set = '0;
  logic [127:0] got_q[$];
  int          launch_cyc_q[$], done_cyc_q[$];

  typedef struct {
    logic [47:0] f;
    logic [47:0] d;
    logic [31:0] r;
    int          nburst;
    int          rise;
    int          fall;
  } vec_t;

  vec_t tbl[$];

  assign ACK = resp_en ? ack_rsp : ack_man;

  chirp_cfg_tx #(.TIMEOUT_CYC(16)) dut (
    .clk_48(clk_48), .rst(rst), .cfg_wr(cfg_wr),
    .cfg_freq(cfg_freq), .cfg_delta_freq(cfg_delta_freq), .cfg_delta_rate(cfg_delta_rate),
    .REQ(REQ), .ACK(ACK),
    .DDS_freq(DDS_freq), .DDS_delta_freq(DDS_delta_freq), .DDS_delta_rate(DDS_delta_rate),
    .busy(busy), .done(done), .overrun(overrun), .timeout_err(timeout_err)
  );

  initial forever #5 clk_48 = ~clk_48;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // clk_96-side responder: ACK follows REQ after a programmable number of cycles
  initial begin
    int cnt;
    cnt = 0;
    ack_rsp = 1'b0;
    forever begin
      @(negedge clk_48);
      if (!resp_en) begin
        ack_rsp = 1'b0;
        cnt = 0;
      end else if (REQ !== ack_rsp) begin
        if (cnt >= (REQ ? resp_rise : resp_fall)) begin
          ack_rsp = REQ;
          cnt = 0;
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // transfer monitor: records launched sets, done pulses and DDS stability
  always @(negedge clk_48) begin
    cyc++;
    if (REQ && !prev_req) begin
      cur_set = {DDS_freq, DDS_delta_freq, DDS_delta_rate};
      got_q.push_back(cur_set);
      launch_cyc_q.push_back(cyc);
    end
    if (busy && ({DDS_freq, DDS_delta_freq, DDS_delta_rate} !== cur_set))
      stable_err++;
    if (done) begin
      done_cnt++;
      done_cyc_q.push_back(cyc);
    end
    prev_req = REQ;
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic nedge();
    @(negedge clk_48);
    #1;
  endtask

  task automatic drive(input logic wr, input logic [127:0] s);
    cfg_wr         = wr;
    cfg_freq       = s[127:80];
    cfg_delta_freq = s[79:32];
    cfg_delta_rate = s[31:0];
  endtask

  task automatic do_reset();
    nedge();
    resp_en = 1'b0;
    ack_man = 1'b0;
    drive(1'b0, '0);
    rst = 1'b1;
    repeat (2) nedge();
    rst = 1'b0;
    repeat (3) nedge();
  endtask

  // waits until REQ equals lvl; returns the number of cycles taken (-1 if bound expired)
  task automatic wait_req(input logic lvl, input int max_c, output int n);
    n = 0;
    while (REQ !== lvl && n < max_c) begin
      nedge();
      n++;
    end
    if (REQ !== lvl) n = -1;
  endtask

  task automatic finish_handshake(input string nm);
    int n;
    ack_man = 1'b1;
    wait_req(1'b0, 30, n);
    chk({nm, "_req_drop"}, (n >= 0), 1);
    ack_man = 1'b0;
    n = 0;
    while (busy && n < 30) begin
      nedge();
      n++;
    end
    chk({nm, "_idle"}, busy, 0);
  endtask

  task automatic run_case(input int idx, input vec_t v);
    logic [127:0] lead, s, exp_q[$];
    int g0, d0, s0, k, n_exp;
    string nm;
    nm = $sformatf("case%0d", idx);
    do_reset();
    resp_rise = v.rise;
    resp_fall = v.fall;
    resp_en   = 1'b1;
    g0 = got_q.size();
    d0 = done_cyc_q.size();
    s0 = stable_err;
    lead = {v.f, v.d, v.r};
    exp_q.push_back(lead);
    drive(1'b1, lead);
    nedge();
    s = lead;
    for (int i = 0; i < v.nburst; i++) begin
      s = {v.f + 48'(i + 1) * 48'h1111_0001, v.d ^ 48'(i + 1), v.r + 32'(i + 1)};
      drive(1'b1, s);
      nedge();
    end
    drive(1'b0, '0);
    if (v.nburst > 0) exp_q.push_back(s);
    n_exp = exp_q.size();
    k = 0;
    while ((done_cyc_q.size() - d0) < n_exp && k < 400) begin
      nedge();
      k++;
    end
    chk({nm, "_done_wait"}, ((done_cyc_q.size() - d0) >= n_exp), 1);
    repeat (10) nedge();
    chk({nm, "_xfer_count"}, got_q.size() - g0, n_exp);
    chk({nm, "_done_count"}, done_cyc_q.size() - d0, n_exp);
    for (int i = 0; i < n_exp && (g0 + i) < got_q.size(); i++)
      chk($sformatf("%s_xfer%0d", nm, i), got_q[g0 + i], exp_q[i]);
    chk({nm, "_overrun"}, overrun, (v.nburst >= 2));
    chk({nm, "_dds_stable"}, stable_err - s0, 0);
    if (n_exp == 2 && got_q.size() > g0 + 1 && done_cyc_q.size() > d0)
      chk({nm, "_launch_gap"}, launch_cyc_q[g0 + 1] - done_cyc_q[d0], 1);
    resp_en = 1'b0;
  endtask

  initial begin
    logic [127:0] s1, s2;
    vec_t v;
    int n, d0, g0;

    rst = 1'b1;
    resp_en = 1'b0;
    ack_man = 1'b0;
    resp_rise = 4;
    resp_fall = 4;
    drive(1'b0, '0);
    repeat (3) nedge();

    chk("rst_req", REQ, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_timeout", timeout_err, 0);
    chk("rst_dds", {DDS_freq, DDS_delta_freq, DDS_delta_rate}, 0);
    rst = 1'b0;
    repeat (3) nedge();

    // single transfer with exact handshake timing, then a cfg_wr on the REQ_LO->IDLE edge
    s1 = {48'h2800_0000_0000, 48'h10, 32'd95};
    s2 = {48'h1234_5678_9ABC, 48'h0000_0000_0F00, 32'd7};
    d0 = done_cnt;
    g0 = got_q.size();
    drive(1'b1, s1);
    nedge();
    drive(1'b0, '0);
    chk("single_req_rise", REQ, 1);
    chk("single_busy", busy, 1);
    chk("single_dds", {DDS_freq, DDS_delta_freq, DDS_delta_rate}, s1);
    repeat (4) nedge();
    ack_man = 1'b1;
    wait_req(1'b0, 20, n);
    chk("single_req_fall_delay", n, 3);
    chk("single_busy_reqlo", busy, 1);
    repeat (4) nedge();
    ack_man = 1'b0;
    nedge();
    nedge();
    chk("single_busy_before_done", busy, 1);
    chk("single_no_early_done", done, 0);
    drive(1'b1, s2);
    nedge();
    drive(1'b0, '0);
    chk("single_done", done, 1);
    chk("single_busy_end", busy, 0);
    chk("single_dds_hold", {DDS_freq, DDS_delta_freq, DDS_delta_rate}, s1);
    nedge();
    chk("simul_done_one_pulse", done, 0);
    chk("simul_req", REQ, 1);
    chk("simul_dds", {DDS_freq, DDS_delta_freq, DDS_delta_rate}, s2);
    finish_handshake("simul");
    repeat (3) nedge();
    chk("simul_done_count", done_cnt - d0, 2);
    chk("simul_xfer_count", got_q.size() - g0, 2);
    chk("simul_overrun", overrun, 0);

    // reset in REQ_HI while ACK is high; launch must wait for ack_s low
    do_reset();
    drive(1'b1, s1);
    nedge();
    drive(1'b0, '0);
    ack_man = 1'b1;
    nedge();
    rst = 1'b1;
    nedge();
    rst = 1'b0;
    chk("rstmid_req", REQ, 0);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_flags", {done, overrun, timeout_err}, 0);
    chk("rstmid_dds", {DDS_freq, DDS_delta_freq, DDS_delta_rate}, 0);
    drive(1'b1, s2);
    nedge();
    drive(1'b0, '0);
    n = 0;
    for (int i = 0; i < 8; i++) begin
      if (REQ) n++;
      nedge();
    end
    chk("rstmid_no_launch_ack_hi", n, 0);
    ack_man = 1'b0;
    wait_req(1'b1, 20, n);
    chk("rstmid_launch_delay", n, 3);
    chk("rstmid_dds", {DDS_freq, DDS_delta_freq, DDS_delta_rate}, s2);
    finish_handshake("rstmid");

    // timeout behaviour (or its absence)
    do_reset();
    d0 = done_cnt;
    drive(1'b1, s1);
    nedge();
    drive(1'b0, '0);
    n = 0;
    while (REQ && n < 60) begin
      nedge();
      n++;
    end
`ifdef CHIRP_TX_TIMEOUT_EN
    chk("timeout_req_cycles", n, 16);
    chk("timeout_err_set", timeout_err, 1);
    chk("timeout_busy", busy, 0);
    repeat (3) nedge();
    chk("timeout_no_done", done_cnt - d0, 0);
    chk("timeout_sticky", timeout_err, 1);
    drive(1'b1, s2);
    nedge();
    drive(1'b0, '0);
    chk("timeout_err_clear", timeout_err, 0);
    chk("timeout_relaunch", REQ, 1);
    finish_handshake("timeout");
`else
    chk("notimeout_req_held", n, 60);
    chk("notimeout_err", timeout_err, 0);
    chk("notimeout_no_done", done_cnt - d0, 0);
    finish_handshake("notimeout");
`endif

    // table of transfer cases, then randomized ones
    tbl.push_back('{48'h2800_0000_0000, 48'h10, 32'd95, 0, 4, 4});
    tbl.push_back('{48'h0000_0100_0000, 48'h20, 32'd10, 1, 5, 3});
    tbl.push_back('{48'h0A0A_0A0A_0A0A, 48'h30, 32'd1,  2, 4, 2});
    tbl.push_back('{48'h5555_AAAA_5555, 48'h40, 32'd0,  3, 6, 5});
    tbl.push_back('{48'hFFFF_FFFF_FFFF, 48'hFFFF_FFFF_FFFF, 32'hFFFF_FFFF, 0, 8, 1});
    for (int i = 0; i < 6; i++) begin
      v.f = {16'($urandom), $urandom};
      v.d = {16'($urandom), $urandom};
      v.r = $urandom;
      v.nburst = $urandom_range(0, 3);
      v.rise = $urandom_range(3, 8);
      v.fall = $urandom_range(1, 6);
      tbl.push_back(v);
    end
    foreach (tbl[i]) run_case(i, tbl[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
